// File: rtl/glitcbus_pkg.sv
// Shared GLITCBUS slave definitions: FSM encoding and the edge numbers (k) of each bus phase.
package glitcbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    W_DATA,
    R_DATA,
    FINISH
  } state_t;

  localparam int ADDR_HI_EDGE  = 1;
  localparam int ADDR_LO_EDGE  = 2;
  localparam int RD_DRIVE_EDGE = 3;
  localparam int WR_FIRST_EDGE = 4;
  localparam int LAST_EDGE     = 7;

  // Byte-counter value in ADDR_LO marking the write wait edge, and its final value in data phases.
  localparam logic [1:0] WR_WAIT_CNT   = 2'(RD_DRIVE_EDGE - ADDR_LO_EDGE);
  localparam logic [1:0] DATA_LAST_CNT = 2'(LAST_EDGE - WR_FIRST_EDGE);

endpackage

// File: rtl/glitcbus_iob.sv
// 8-bit registered tristate for GAD; data and enable flops are meant to pack into the I/O cells.
// Async reset clears the enable, so the pad is released without waiting for a clock edge.
module glitcbus_iob (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ld,
  input  logic [7:0] dat,
  input  logic       oe,
  inout  wire  [7:0] pad,
  output logic [7:0] din
);

  (* IOB = "TRUE" *) logic [7:0] dat_q;
  (* IOB = "TRUE" *) logic       oe_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dat_q <= 8'h00;
      oe_q  <= 1'b0;
    end else if (ld) begin
      dat_q <= dat;
      oe_q  <= oe;
    end
  end

  assign pad = oe_q ? dat_q : 8'bzzzz_zzzz;
  assign din = pad;

endmodule

// File: rtl/glitcbus_slave.sv
// GLITCBUS slave: byte-serial address/data from the TISC master mapped to single-cycle internal bus strobes.
// Optional aborted-transaction counter on abort_count_o when GLITCBUS_SLAVE_ABORT_COUNT_EN is defined.
module glitcbus_slave
  import glitcbus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        GSEL_B,
  input  logic        GRDWR_B,
  inout  wire  [7:0]  GAD,
  output logic [15:0] gb_adr_o,
  output logic [31:0] gb_dat_o,
  output logic        gb_wr_o,
  output logic        gb_rd_o,
  input  logic [31:0] gb_dat_i
`ifdef GLITCBUS_SLAVE_ABORT_COUNT_EN
  ,
  output logic [7:0]  abort_count_o
`endif
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        armed_q;
  logic [23:0] shift_q, shift_d;
  logic [15:0] adr_d;
  logic [31:0] dat_d;
  logic        wr_d, rd_d;
  logic        drv_ld, drv_oe;
  logic [7:0]  drv_dat;
  logic [7:0]  gad_in;
  logic        abort;

  glitcbus_iob u_iob (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .ld      (drv_ld),
    .dat     (drv_dat),
    .oe      (drv_oe),
    .pad     (GAD),
    .din     (gad_in)
  );

  // Deselect mid-transaction abandons it; FINISH is the normal wait for deselect.
  assign abort = GSEL_B && (state_q != IDLE) && (state_q != FINISH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    adr_d   = gb_adr_o;
    dat_d   = gb_dat_o;
    shift_d = shift_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    drv_ld  = 1'b0;
    drv_oe  = 1'b0;
    drv_dat = shift_q[23:16];
    if (abort) begin
      state_d = IDLE;
      drv_ld  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // armed_q blocks a start until a deselected edge has been seen
          if (!GSEL_B && armed_q) begin
            state_d = ADDR_HI;
            cnt_d   = 2'd0;
          end
        end
        ADDR_HI: begin
          adr_d[15:8] = gad_in;
          dir_d       = GRDWR_B;
          cnt_d       = 2'd0;
          state_d     = ADDR_LO;
        end
        ADDR_LO: begin
          if (cnt_q != WR_WAIT_CNT) begin
            adr_d[7:0] = gad_in;
            if (dir_q) begin
              rd_d    = 1'b1;
              state_d = R_DATA;
            end else begin
              cnt_d = WR_WAIT_CNT;
            end
          end else begin
            cnt_d   = 2'd0;
            state_d = W_DATA;
          end
        end
        W_DATA: begin
          case (cnt_q)
            2'd0:    dat_d[31:24] = gad_in;
            2'd1:    dat_d[23:16] = gad_in;
            2'd2:    dat_d[15:8]  = gad_in;
            default: dat_d[7:0]   = gad_in;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == DATA_LAST_CNT) begin
            wr_d    = 1'b1;
            state_d = FINISH;
          end
        end
        R_DATA: begin
          drv_ld = 1'b1;
          drv_oe = 1'b1;
          // gb_rd_o is high exactly in the cycle before the drive edge
          if (gb_rd_o) begin
            drv_dat = gb_dat_i[31:24];
            shift_d = gb_dat_i[23:0];
          end else if (cnt_q == DATA_LAST_CNT) begin
            drv_oe  = 1'b0;
            state_d = FINISH;
          end else begin
            shift_d = {shift_q[15:0], 8'h00};
            cnt_d   = cnt_q + 2'd1;
          end
        end
        FINISH: begin
          if (GSEL_B) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      dir_q    <= 1'b0;
      armed_q  <= 1'b0;
      shift_q  <= 24'h0;
      gb_adr_o <= 16'h0;
      gb_dat_o <= 32'h0;
      gb_wr_o  <= 1'b0;
      gb_rd_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      armed_q  <= GSEL_B;
      shift_q  <= shift_d;
      gb_adr_o <= adr_d;
      gb_dat_o <= dat_d;
      gb_wr_o  <= wr_d;
      gb_rd_o  <= rd_d;
    end
  end

`ifdef GLITCBUS_SLAVE_ABORT_COUNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      abort_count_o <= 8'h00;
    end else if (abort && (abort_count_o != 8'hFF)) begin
      abort_count_o <= abort_count_o + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_glitcbus_slave.sv
// Bench for glitcbus_slave: table of master transactions, internal-bus strobes checked against a scoreboard queue.
module tb_glitcbus_slave;

  localparam int NA = 99;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        GSEL_B;
  logic        GRDWR_B;
  wire  [7:0]  GAD;
  logic [7:0]  m_dat;
  logic        m_oe;
  logic [15:0] gb_adr_o;
  logic [31:0] gb_dat_o;
  logic        gb_wr_o;
  logic        gb_rd_o;
  logic [31:0] gb_dat_i;
  logic [31:0] rd_data;
`ifdef GLITCBUS_SLAVE_ABORT_COUNT_EN
  logic [7:0]  abort_count_o;
  int          exp_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;

  typedef struct {
    bit          rd;
    logic [15:0] adr;
    logic [31:0] dat;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    bit          rd;
    logic [15:0] adr;
    logic [31:0] dat;
    int          abort_k;
    int          rst_k;
    bit          hold;
    bit          exp_strobe;
    bit          exp_abort;
  } vec_t;
  vec_t vt[14];

  assign GAD = m_oe ? m_dat : 8'bzzzz_zzzz;
  // Internal register file: read data only valid while the read strobe is up.
  assign gb_dat_i = gb_rd_o ? rd_data : 32'h0BAD0BAD;

  always #5 clk_i = ~clk_i;

  glitcbus_slave dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .GSEL_B   (GSEL_B),
    .GRDWR_B  (GRDWR_B),
    .GAD      (GAD),
    .gb_adr_o (gb_adr_o),
    .gb_dat_o (gb_dat_o),
    .gb_wr_o  (gb_wr_o),
    .gb_rd_o  (gb_rd_o),
    .gb_dat_i (gb_dat_i)
`ifdef GLITCBUS_SLAVE_ABORT_COUNT_EN
    ,
    .abort_count_o (abort_count_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i && (gb_wr_o || gb_rd_o)) begin
      n_strobe++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, gb_wr_o, gb_rd_o}, 32'd0);
      end else begin
        ev_t ev;
        ev = sb.pop_front();
        chk("strobe_kind", {30'd0, gb_wr_o, gb_rd_o}, ev.rd ? 32'd1 : 32'd2);
        chk("strobe_adr", {16'd0, gb_adr_o}, {16'd0, ev.adr});
        if (!ev.rd) chk("wr_dat", gb_dat_o, ev.dat);
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_oe"}, {31'd0, dut.u_iob.oe_q}, 32'd0);
    chk({tag, "_adr"}, {16'd0, gb_adr_o}, 32'd0);
    chk({tag, "_dat"}, gb_dat_o, 32'd0);
    chk({tag, "_strobes"}, {30'd0, gb_wr_o, gb_rd_o}, 32'd0);
`ifdef GLITCBUS_SLAVE_ABORT_COUNT_EN
    exp_cnt = 0;
    chk({tag, "_abort_cnt"}, {24'd0, abort_count_o}, 32'd0);
`endif
  endtask

  task automatic do_txn(input vec_t v);
    int s;
    rd_data = v.dat;
    if (v.exp_strobe) sb.push_back('{v.rd, v.adr, v.dat});
    for (int k = 0; k <= 7; k++) begin
      if (v.rd && k >= 4) chk($sformatf("rd_byte_k%0d", k), {24'd0, GAD}, {24'd0, v.dat[8*(7-k) +: 8]});
      chk($sformatf("gad_oe_k%0d", k), {31'd0, dut.u_iob.oe_q}, {31'd0, (v.rd && k >= 4)});
      if (k == v.rst_k) begin
        rst_n_i = 1'b0;
        #1;
        reset_checks("rst_async");
        m_oe = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        s = n_strobe;
        repeat (12) begin
          m_oe = 1'b1; m_dat = 8'($urandom); GRDWR_B = 1'($urandom);
          @(negedge clk_i);
        end
        chk("no_start_after_reset", n_strobe - s, 32'd0);
        m_oe = 1'b0; GSEL_B = 1'b1;
        @(negedge clk_i);
        return;
      end
      if (k == v.abort_k) begin
        GSEL_B = 1'b1; m_oe = 1'b0;
        @(negedge clk_i);
        chk("abort_release", {31'd0, dut.u_iob.oe_q}, 32'd0);
`ifdef GLITCBUS_SLAVE_ABORT_COUNT_EN
        exp_cnt += int'(v.exp_abort);
        chk("abort_cnt", {24'd0, abort_count_o}, exp_cnt);
`endif
        return;
      end
      GSEL_B  = 1'b0;
      GRDWR_B = (k <= 1) ? v.rd : ~v.rd;
      case (k)
        0, 1:    m_dat = v.adr[15:8];
        2:       m_dat = v.adr[7:0];
        3:       m_dat = 8'h5A;
        default: m_dat = v.dat[8*(7-k) +: 8];
      endcase
      m_oe = !(v.rd && k >= 3);
      @(negedge clk_i);
    end
    chk("gad_released_end", {31'd0, dut.u_iob.oe_q}, 32'd0);
    m_oe = 1'b0;
    if (v.hold) begin
      @(negedge clk_i);
      s = n_strobe;
      repeat (11) begin
        m_oe = 1'b1; m_dat = 8'($urandom); GRDWR_B = 1'($urandom);
        @(negedge clk_i);
      end
      chk("no_restart_held_low", n_strobe - s, 32'd0);
      m_oe = 1'b0;
    end
    GSEL_B = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        rd adr       dat           abort rst hold strobe abort
    vt[0]  = '{0, 16'h1234, 32'hDEADBEEF, NA, NA, 0, 1, 0};
    vt[1]  = '{1, 16'h00A5, 32'hCAFEF00D, NA, NA, 0, 1, 0};
    vt[2]  = '{0, 16'h5555, 32'h01234567, 5,  NA, 0, 0, 1};
    vt[3]  = '{0, 16'hAAAA, 32'h89ABCDEF, NA, NA, 0, 1, 0};
    vt[4]  = '{0, 16'h0F0F, 32'h11112222, NA, NA, 0, 1, 0};
    vt[5]  = '{0, 16'hF0F0, 32'h33334444, NA, NA, 0, 1, 0};
    vt[6]  = '{1, 16'h8001, 32'h12345678, 3,  NA, 0, 1, 1};
    vt[7]  = '{1, 16'h7FFE, 32'hA5A55A5A, 2,  NA, 0, 0, 1};
    vt[8]  = '{0, 16'h0000, 32'hFFFFFFFF, 7,  NA, 0, 0, 1};
    vt[9]  = '{1, 16'h0100, 32'h00FF00FF, 6,  NA, 0, 1, 1};
    vt[10] = '{1, 16'h4321, 32'h87654321, NA, 5,  0, 1, 0};
    vt[11] = '{1, 16'h0001, 32'h5A5AA5A5, NA, NA, 0, 1, 0};
    vt[12] = '{0, 16'h1357, 32'h2468ACE0, 1,  NA, 0, 0, 1};
    vt[13] = '{0, 16'hBEEF, 32'h0BADF00D, NA, NA, 1, 1, 0};

    rst_n_i = 1'b0; GSEL_B = 1'b1; GRDWR_B = 1'b0; m_oe = 1'b0; m_dat = 8'h00; rd_data = 32'h0;
    #2;
    reset_checks("por");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 14; i++) do_txn(vt[i]);

    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb.size(), 32'd0);

`ifdef GLITCBUS_SLAVE_ABORT_COUNT_EN
    for (int i = 0; i < 300; i++) begin
      GSEL_B = 1'b0; m_oe = 1'b1; m_dat = 8'(i);
      @(negedge clk_i);
      GSEL_B = 1'b1; m_oe = 1'b0;
      @(negedge clk_i);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk("abort_cnt_sat", {24'd0, abort_count_o}, exp_cnt);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitcbus_slave.md
GLITCBUS_SLAVE -- requirements
Module: glitcbus_slave

Interface
REQ-001 The module SHALL have no parameters; address width is 16 and data width is 32, both fixed.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk_i  input  1  GLITCBUS clock (GCLK); every register samples on the rising edge.
REQ-004 rst_n_i  input  1  asynchronous active-low reset.
REQ-005 GSEL_B  input  1  chip select from the TISC master, active low.
REQ-006 GRDWR_B  input  1  direction: 0 = write, 1 = read; sampled with the address high byte.
REQ-007 GAD  inout  8  multiplexed address/data bus; the slave drives it only in read data phases.
REQ-008 gb_adr_o  output  16  register address for the internal bus.
REQ-009 gb_dat_o  output  32  write data for the internal bus.
REQ-010 gb_wr_o  output  1  one-cycle internal write strobe.
REQ-011 gb_rd_o  output  1  one-cycle internal read strobe.
REQ-012 gb_dat_i  input  32  read data, combinationally valid in the cycle gb_rd_o is high.
REQ-013 abort_count_o  output  8  aborted-transaction count; present only with the macro in REQ-031.

Function
REQ-014 Edge k=0 SHALL be the first rising edge that samples GSEL_B=0 while the FSM is in IDLE; k=1, 2, ... are the following edges.
REQ-015 FSM states SHALL be IDLE, ADDR_HI, ADDR_LO, W_DATA, R_DATA, FINISH.
- A 2-bit byte counter sequences the W_DATA and R_DATA phases.
REQ-016 At k=1 the FSM SHALL capture GAD into gb_adr_o[15:8] and GRDWR_B into the direction bit.
REQ-017 At k=2 the FSM SHALL capture GAD into gb_adr_o[7:0].
REQ-018 Write: the edge at k=3 is a wait edge with no capture.
- k=4, 5, 6, 7 capture GAD into gb_dat_o[31:24], [23:16], [15:8], [7:0] respectively.
REQ-019 Write: gb_wr_o SHALL be high only in the cycle after k=7, with gb_adr_o and gb_dat_o valid in that cycle.
REQ-020 Read: gb_rd_o SHALL be high only in the cycle after k=2.
- At k=3 the slave registers gb_dat_i, drives byte3 on GAD and enables the output driver.
REQ-021 Read: k=4, 5, 6 SHALL shift byte2, byte1, byte0 onto GAD.
- The driver is disabled at k=7.
- Net effect: the master samples byte N at edge k=7-N.
REQ-022 Bus turnaround: the GAD driver and its enable SHALL be IOB registers, and the enable SHALL be high only between edges k=3 and k=7.
REQ-023 After the final data edge the FSM SHALL enter FINISH and return to IDLE on the first edge that samples GSEL_B=1.
- No new transaction starts while in FINISH.
REQ-024 Abort: if GSEL_B is sampled 1 in any state other than IDLE or FINISH, the FSM SHALL go to IDLE on that edge.
- On abort: GAD is released and no gb_wr_o is issued (gb_rd_o, if already issued, stands).
REQ-025 GSEL_B held low with no pause between transactions SHALL NOT start a second transaction.
- A new transaction requires at least one edge with GSEL_B sampled 1.
REQ-026 GRDWR_B changes after k=1 SHALL be ignored.

Reset
REQ-027 Assertion of rst_n_i SHALL asynchronously force:
- FSM to IDLE;
- GAD enable off;
- gb_wr_o and gb_rd_o to 0;
- gb_adr_o, gb_dat_o, the GAD output register and abort_count_o to 0.
REQ-028 Reset during a read SHALL release GAD immediately, without waiting for a clock edge.
REQ-029 After rst_n_i deasserts, the FSM SHALL wait for GSEL_B to be sampled 1 before accepting k=0.

Configuration
REQ-030 Exactly one optional feature SHALL exist, controlled by macro GLITCBUS_SLAVE_ABORT_COUNT_EN.
REQ-031 With the macro defined: abort_count_o SHALL increment by 1 on each abort (REQ-024) and saturate at 255.
REQ-032 Without the macro: the abort_count_o port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-033 A shared package glitcbus_pkg SHALL hold:
- the state encoding;
- the phase-edge constants (ADDR_HI_EDGE=1, ADDR_LO_EDGE=2, RD_DRIVE_EDGE=3, WR_FIRST_EDGE=4, LAST_EDGE=7).
REQ-034 One sub-module, glitcbus_iob (the 8-bit registered tristate with IOB-packed output and enable), SHALL be instantiated.
- All other logic stays in glitcbus_slave.

Verification
REQ-035 Write address 0x1234, data 0xDEADBEEF, using the master timing:
- gb_wr_o pulses once in the cycle after k=7 with gb_adr_o=0x1234 and gb_dat_o=0xDEADBEEF;
- GAD is never driven by the slave.
REQ-036 Read address 0x00A5 with gb_dat_i=0xCAFEF00D:
- gb_rd_o pulses once after k=2;
- the master samples 0xCA, 0xFE, 0xF0, 0x0D at k=4..7;
- GAD is Z at k=2 and from k=7 onward.
REQ-037 Write aborted by GSEL_B=1 at k=5:
- no gb_wr_o;
- FSM returns to IDLE;
- abort_count_o goes 0 to 1 (macro on).
REQ-038 Reset asserted at k=4 of a read: GAD goes Z asynchronously and the next read of 0x0001 completes correctly.
REQ-039 Two back-to-back writes separated by one GSEL_B-high edge: both produce exactly one gb_wr_o each with the correct address and data.
REQ-040 Force 300 aborts with the macro on: abort_count_o saturates at 255.
